// File: rtl/flipflop_jk_pkg.sv
// ---------------------------------------------------------------------------
// flipflop_jk_pkg
//   Shared definitions for the JK flip-flop slice and its wrapper.
//   - JK_* : 2-bit operation codes, formed as {J,K}.
//   - jk_next() : next-state function of a single JK slice.
// ---------------------------------------------------------------------------
package flipflop_jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Next state of one slice given its {J,K} code and present state.
  // An unknown present state stays unknown under hold and toggle, which
  // is the intended power-up behaviour in simulation.
  function automatic logic jk_next(input logic [1:0] code, input logic q);
    logic nxt;
    case (code)
      JK_HOLD:   nxt = q;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/flipflop_jk_bit.sv
// ---------------------------------------------------------------------------
// jk_bit
//   One edge-triggered JK storage slice with asynchronous clear and preset.
//   Ports:
//     clockpulse  in  rising-edge clock
//     clear       in  asynchronous clear, active-high, forces q=0 (wins)
//     preset      in  asynchronous preset, active-low, forces q=1
//     jack        in  J input
//     kilby       in  K input
//     q           out stored state
//   The state register is deliberately left without a power-up value: it
//   is unknown until clear, preset or a defining J/K edge.
// ---------------------------------------------------------------------------
module jk_bit
  import flipflop_jk_pkg::*;
(
  input  logic clockpulse,
  input  logic clear,
  input  logic preset,
  input  logic jack,
  input  logic kilby,
  output logic q
);

  logic [1:0] jk_code_s;
  logic       next_s;
  logic       state_r;

  assign jk_code_s = {jack, kilby};

  // Next-state decode from the J/K code sampled at the edge.
  always_comb begin
    next_s = jk_next(jk_code_s, state_r);
  end

  // State register: clear dominates preset; both override any clock edge
  // that arrives while they are asserted. Releasing either produces no
  // event here, so the forced value is held until the next rising edge.
  always_ff @(posedge clockpulse or posedge clear or negedge preset) begin
    if (clear) begin
      state_r <= 1'b0;
    end else if (!preset) begin
      state_r <= 1'b1;
    end else begin
      state_r <= next_s;
    end
  end

  assign q = state_r;

endmodule

// File: rtl/flipflop_jk.sv
// ---------------------------------------------------------------------------
// flipflop_jk
//   WIDTH independent JK flip-flops sharing clock, clear and preset.
//   Ports:
//     clockpulse  in  1      rising-edge clock
//     clear       in  1      asynchronous clear, active-high, out=0
//     preset      in  1      asynchronous preset, active-low, out=1
//     jack        in  WIDTH  J per slice
//     kilby       in  WIDTH  K per slice
//     out         out WIDTH  Q
//     notout      out WIDTH  /Q, combinational inverse of out
//   Slices do not interact; there is no carry between bits.
// ---------------------------------------------------------------------------
module flipflop_jk
  import flipflop_jk_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd1
) (
  input  logic             clockpulse,
  input  logic             clear,
  input  logic             preset,
  input  logic [WIDTH-1:0] jack,
  input  logic [WIDTH-1:0] kilby,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] notout
);

  logic [WIDTH-1:0] slice_q_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    jk_bit u_jk_bit (
      .clockpulse (clockpulse),
      .clear      (clear),
      .preset     (preset),
      .jack       (jack[i]),
      .kilby      (kilby[i]),
      .q          (slice_q_s[i])
    );
  end

  // The complement is derived from the same state, so out and notout can
  // never agree, even with clear and preset asserted together.
  assign out    = slice_q_s;
  assign notout = ~slice_q_s;

endmodule

// File: tb/tb_flipflop_jk.sv
// ---------------------------------------------------------------------------
// tb_flipflop_jk
//   Directed bench for flipflop_jk (WIDTH=1). Stimulus pushes the expected
//   Q into a queue and raises a sample strobe; a separate monitor pops the
//   expectation and compares out and notout.
// ---------------------------------------------------------------------------
module tb_flipflop_jk;

  logic       clockpulse = 1'b0;
  logic       clear      = 1'b0;
  logic       preset     = 1'b1;
  logic [0:0] jack       = 1'b0;
  logic [0:0] kilby      = 1'b0;
  logic [0:0] out;
  logic [0:0] notout;

  logic sample_req = 1'b0;

  typedef struct {
    logic  q;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  flipflop_jk #(.WIDTH(32'd1)) dut (
    .clockpulse (clockpulse),
    .clear      (clear),
    .preset     (preset),
    .jack       (jack),
    .kilby      (kilby),
    .out        (out),
    .notout     (notout)
  );

  // Monitor: pop one expectation per sample strobe and compare.
  always @(posedge sample_req) begin
    exp_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_sample: got out=%b, no expectation queued", out);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      if (out !== e.q) begin
        n_fail++;
        $display("FAIL %s: out=%b expected %b", e.name, out, e.q);
      end
      n_cmp++;
      if (notout !== ~e.q) begin
        n_fail++;
        $display("FAIL %s_n: notout=%b expected %b", e.name, notout, ~e.q);
      end
    end
  end

  task automatic check(input logic q, input string name);
    exp_t e;
    e.q    = q;
    e.name = name;
    exp_q.push_back(e);
    sample_req = 1'b1;
    #1;
    sample_req = 1'b0;
    #1;
  endtask

  task automatic rise();
    clockpulse = 1'b1;
    #2;
  endtask

  task automatic fall();
    clockpulse = 1'b0;
    #2;
  endtask

  task automatic edge_check(input logic [1:0] jk, input logic q, input string name);
    jack  = jk[1];
    kilby = jk[0];
    #2;
    rise();
    check(q, name);
    fall();
  endtask

  initial begin
    // 1: clear held while clocking with arbitrary J/K
    #1;
    clear = 1'b1;
    #2;
    check(1'b0, "reset");
    edge_check(2'b11, 1'b0, "clear_jk11");
    edge_check(2'b10, 1'b0, "clear_jk10");
    clear = 1'b0;
    #2;
    check(1'b0, "clear_release");

    // 2: hold and reset
    edge_check(2'b00, 1'b0, "hold0");
    edge_check(2'b01, 1'b0, "reset0");

    // 3: set and hold
    edge_check(2'b10, 1'b1, "set");
    edge_check(2'b00, 1'b1, "hold1");

    // 4: toggle on rising edges only
    jack  = 1'b1;
    kilby = 1'b1;
    #2;
    rise();
    check(1'b0, "toggle1_rise");
    fall();
    check(1'b0, "toggle1_fall");
    rise();
    check(1'b1, "toggle2_rise");
    fall();
    check(1'b1, "toggle2_fall");
    rise();
    check(1'b0, "toggle3_rise");
    fall();

    // 5: asynchronous preset / clear priority with the clock idle
    jack  = 1'b0;
    kilby = 1'b0;
    #2;
    preset = 1'b0;
    #2;
    check(1'b1, "preset_async");
    clear = 1'b1;
    #2;
    check(1'b0, "clear_wins");
    clear  = 1'b0;
    preset = 1'b1;
    #2;
    check(1'b0, "release_both");

    // clear overrides a concurrent set edge
    clear = 1'b1;
    edge_check(2'b10, 1'b0, "clear_over_edge");
    clear = 1'b0;
    #2;
    // preset overrides a concurrent reset edge
    preset = 1'b0;
    edge_check(2'b01, 1'b1, "preset_over_edge");
    preset = 1'b1;
    #2;
    check(1'b1, "preset_release");
    edge_check(2'b01, 1'b0, "reset_after_preset");

    // 6: J pulse only while clock is low has no effect
    jack  = 1'b1;
    kilby = 1'b0;
    #2;
    check(1'b0, "glitch_low");
    jack = 1'b0;
    #2;
    edge_check(2'b00, 1'b0, "no_ones_catch");

    // drain the scoreboard within a bounded time
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) break;
      #1;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "timeout");
  end

endmodule
